// File: rtl/branch_rs.sv
`default_nettype none
// ============================================================================
//  Module      : branch_rs
//  Description : Reservation station for conditional branches. Buffers up to
//                RS_DEPTH branch micro-ops, captures operands from the CDB,
//                and issues the oldest fully-ready entry each cycle through a
//                registered port to branch_unit. An age matrix orders entries
//                independently of their slot index.
//  Option      : BRS_DISPATCH_BYPASS_EN - when defined, a dispatching source
//                whose tag is on the CDB in the same cycle is captured ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_rs #(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int PREG_WIDTH = 6,
    parameter int RS_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_flush,
    input  logic                            i_disp_valid,
    output logic                            o_disp_ready,
    input  logic [DATA_WIDTH-1:0]           i_disp_pc,
    input  logic [DATA_WIDTH-1:0]           i_disp_imm,
    input  logic [2:0]                      i_disp_funct3,
    input  logic [ROB_WIDTH-1:0]            i_disp_rob_tag,
    input  logic                            i_disp_src1_rdy,
    input  logic [PREG_WIDTH-1:0]           i_disp_src1_tag,
    input  logic [DATA_WIDTH-1:0]           i_disp_src1_val,
    input  logic                            i_disp_src2_rdy,
    input  logic [PREG_WIDTH-1:0]           i_disp_src2_tag,
    input  logic [DATA_WIDTH-1:0]           i_disp_src2_val,
    input  logic                            i_cdb_valid,
    input  logic [PREG_WIDTH-1:0]           i_cdb_tag,
    input  logic [DATA_WIDTH-1:0]           i_cdb_data,
    output logic                            o_issue_valid,
    output logic [DATA_WIDTH-1:0]           o_issue_op1,
    output logic [DATA_WIDTH-1:0]           o_issue_op2,
    output logic [DATA_WIDTH-1:0]           o_issue_pc,
    output logic [DATA_WIDTH-1:0]           o_issue_imm,
    output logic [2:0]                      o_issue_funct3,
    output logic [ROB_WIDTH-1:0]            o_issue_rob_tag,
    output logic [$clog2(RS_DEPTH+1)-1:0]   o_count
);

    localparam int c_idx_w = $clog2(RS_DEPTH);
    localparam int c_cnt_w = $clog2(RS_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(RS_DEPTH);

    // Entry storage
    logic [RS_DEPTH-1:0]   r_valid;
    logic [RS_DEPTH-1:0]   r_s1_rdy;
    logic [RS_DEPTH-1:0]   r_s2_rdy;
    logic [DATA_WIDTH-1:0] r_pc     [RS_DEPTH];
    logic [DATA_WIDTH-1:0] r_imm    [RS_DEPTH];
    logic [DATA_WIDTH-1:0] r_s1_val [RS_DEPTH];
    logic [DATA_WIDTH-1:0] r_s2_val [RS_DEPTH];
    logic [2:0]            r_funct3 [RS_DEPTH];
    logic [ROB_WIDTH-1:0]  r_rob_tag[RS_DEPTH];
    logic [PREG_WIDTH-1:0] r_s1_tag [RS_DEPTH];
    logic [PREG_WIDTH-1:0] r_s2_tag [RS_DEPTH];
    // r_older[j][i] = 1 means entry j was dispatched before entry i
    logic [RS_DEPTH-1:0]   r_older  [RS_DEPTH];
    logic [c_cnt_w-1:0]    r_count;

    logic                  w_disp_fire;
    logic [c_idx_w-1:0]    w_free_idx;
    logic [RS_DEPTH-1:0]   w_ready;
    logic [RS_DEPTH-1:0]   w_sel_oh;
    logic                  w_sel_valid;
    logic [c_idx_w-1:0]    w_sel_idx;
    logic                  w_d_s1_rdy;
    logic                  w_d_s2_rdy;
    logic [DATA_WIDTH-1:0] w_d_s1_val;
    logic [DATA_WIDTH-1:0] w_d_s2_val;

    // Readiness comes from registered occupancy only, so a slot freed by an
    // issue in this cycle is not offered to dispatch until the next cycle.
    assign o_disp_ready = (r_count < c_depth);
    assign o_count      = r_count;
    assign w_disp_fire  = i_disp_valid && o_disp_ready && !i_flush;
    assign w_ready      = r_valid & r_s1_rdy & r_s2_rdy;
    assign w_sel_valid  = |w_sel_oh;

    // Lowest-index free slot (scan high to low so the lowest wins)
    always_comb begin
        w_free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = c_idx_w'(i);
        end
    end

    // Age-based select: a ready entry wins when no other ready entry is older
    always_comb begin
        w_sel_oh = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_sel_oh[i] = w_ready[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (j != i && w_ready[j] && r_older[j][i]) w_sel_oh[i] = 1'b0;
            end
        end
    end

    // Encode the one-hot winner (lowest set bit taken as a safety net)
    always_comb begin
        w_sel_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (w_sel_oh[i]) w_sel_idx = c_idx_w'(i);
        end
    end

    // Dispatch source values, optionally bypassing a same-cycle broadcast
    always_comb begin
        w_d_s1_rdy = i_disp_src1_rdy;
        w_d_s1_val = i_disp_src1_val;
        w_d_s2_rdy = i_disp_src2_rdy;
        w_d_s2_val = i_disp_src2_val;
`ifdef BRS_DISPATCH_BYPASS_EN
        if (!i_disp_src1_rdy && i_cdb_valid && (i_cdb_tag == i_disp_src1_tag)) begin
            w_d_s1_rdy = 1'b1;
            w_d_s1_val = i_cdb_data;
        end
        if (!i_disp_src2_rdy && i_cdb_valid && (i_cdb_tag == i_disp_src2_tag)) begin
            w_d_s2_rdy = 1'b1;
            w_d_s2_val = i_cdb_data;
        end
`endif
    end

    // Entry state: flush, CDB wakeup, issue free and dispatch write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= '0;
            r_s1_rdy <= '0;
            r_s2_rdy <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_pc[i]      <= '0;
                r_imm[i]     <= '0;
                r_s1_val[i]  <= '0;
                r_s2_val[i]  <= '0;
                r_funct3[i]  <= '0;
                r_rob_tag[i] <= '0;
                r_s1_tag[i]  <= '0;
                r_s2_tag[i]  <= '0;
                r_older[i]   <= '0;
            end
        end else if (i_flush) begin
            r_valid <= '0;
            for (int i = 0; i < RS_DEPTH; i++) r_older[i] <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (r_valid[i] && i_cdb_valid) begin
                    if (!r_s1_rdy[i] && (r_s1_tag[i] == i_cdb_tag)) begin
                        r_s1_rdy[i] <= 1'b1;
                        r_s1_val[i] <= i_cdb_data;
                    end
                    if (!r_s2_rdy[i] && (r_s2_tag[i] == i_cdb_tag)) begin
                        r_s2_rdy[i] <= 1'b1;
                        r_s2_val[i] <= i_cdb_data;
                    end
                end
            end
            if (w_sel_valid) r_valid[w_sel_idx] <= 1'b0;
            // The free slot is never the selected slot, so no write conflict
            if (w_disp_fire) begin
                r_valid[w_free_idx]   <= 1'b1;
                r_pc[w_free_idx]      <= i_disp_pc;
                r_imm[w_free_idx]     <= i_disp_imm;
                r_funct3[w_free_idx]  <= i_disp_funct3;
                r_rob_tag[w_free_idx] <= i_disp_rob_tag;
                r_s1_rdy[w_free_idx]  <= w_d_s1_rdy;
                r_s1_tag[w_free_idx]  <= i_disp_src1_tag;
                r_s1_val[w_free_idx]  <= w_d_s1_val;
                r_s2_rdy[w_free_idx]  <= w_d_s2_rdy;
                r_s2_tag[w_free_idx]  <= i_disp_src2_tag;
                r_s2_val[w_free_idx]  <= w_d_s2_val;
                for (int j = 0; j < RS_DEPTH; j++) begin
                    r_older[w_free_idx][j] <= 1'b0;
                    if (c_idx_w'(j) != w_free_idx) r_older[j][w_free_idx] <= r_valid[j];
                end
            end
        end
    end

    // Issue register: data fields hold when nothing is selected
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_issue_valid   <= 1'b0;
            o_issue_op1     <= '0;
            o_issue_op2     <= '0;
            o_issue_pc      <= '0;
            o_issue_imm     <= '0;
            o_issue_funct3  <= '0;
            o_issue_rob_tag <= '0;
        end else if (i_flush) begin
            o_issue_valid <= 1'b0;
        end else begin
            o_issue_valid <= w_sel_valid;
            if (w_sel_valid) begin
                o_issue_op1     <= r_s1_val[w_sel_idx];
                o_issue_op2     <= r_s2_val[w_sel_idx];
                o_issue_pc      <= r_pc[w_sel_idx];
                o_issue_imm     <= r_imm[w_sel_idx];
                o_issue_funct3  <= r_funct3[w_sel_idx];
                o_issue_rob_tag <= r_rob_tag[w_sel_idx];
            end
        end
    end

    // Occupancy counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else if (w_disp_fire && !w_sel_valid) begin
            r_count <= r_count + 1'b1;
        end else if (!w_disp_fire && w_sel_valid) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_rs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_rs
//  Description : Directed self-checking bench for branch_rs. Expected issue
//                packets are queued when stimulus is driven and compared,
//                including the issue cycle, when the DUT issues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_rs;

    logic        clk;
    logic        reset;
    logic        i_flush;
    logic        i_disp_valid;
    logic        o_disp_ready;
    logic [31:0] i_disp_pc;
    logic [31:0] i_disp_imm;
    logic [2:0]  i_disp_funct3;
    logic [3:0]  i_disp_rob_tag;
    logic        i_disp_src1_rdy;
    logic [5:0]  i_disp_src1_tag;
    logic [31:0] i_disp_src1_val;
    logic        i_disp_src2_rdy;
    logic [5:0]  i_disp_src2_tag;
    logic [31:0] i_disp_src2_val;
    logic        i_cdb_valid;
    logic [5:0]  i_cdb_tag;
    logic [31:0] i_cdb_data;
    logic        o_issue_valid;
    logic [31:0] o_issue_op1;
    logic [31:0] o_issue_op2;
    logic [31:0] o_issue_pc;
    logic [31:0] o_issue_imm;
    logic [2:0]  o_issue_funct3;
    logic [3:0]  o_issue_rob_tag;
    logic [2:0]  o_count;

    branch_rs #(
        .DATA_WIDTH (32),
        .ROB_WIDTH  (4),
        .PREG_WIDTH (6),
        .RS_DEPTH   (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_flush         (i_flush),
        .i_disp_valid    (i_disp_valid),
        .o_disp_ready    (o_disp_ready),
        .i_disp_pc       (i_disp_pc),
        .i_disp_imm      (i_disp_imm),
        .i_disp_funct3   (i_disp_funct3),
        .i_disp_rob_tag  (i_disp_rob_tag),
        .i_disp_src1_rdy (i_disp_src1_rdy),
        .i_disp_src1_tag (i_disp_src1_tag),
        .i_disp_src1_val (i_disp_src1_val),
        .i_disp_src2_rdy (i_disp_src2_rdy),
        .i_disp_src2_tag (i_disp_src2_tag),
        .i_disp_src2_val (i_disp_src2_val),
        .i_cdb_valid     (i_cdb_valid),
        .i_cdb_tag       (i_cdb_tag),
        .i_cdb_data      (i_cdb_data),
        .o_issue_valid   (o_issue_valid),
        .o_issue_op1     (o_issue_op1),
        .o_issue_op2     (o_issue_op2),
        .o_issue_pc      (o_issue_pc),
        .o_issue_imm     (o_issue_imm),
        .o_issue_funct3  (o_issue_funct3),
        .o_issue_rob_tag (o_issue_rob_tag),
        .o_count         (o_count)
    );

    typedef struct {
        int          due;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [3:0]  rob;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_pass;
    int   n_total;
    int   n_fail;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int due, input logic [31:0] op1, input logic [31:0] op2,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [2:0] f3, input logic [3:0] rob);
        exp_t e;
        e.due = due; e.op1 = op1; e.op2 = op2; e.pc = pc; e.imm = imm; e.f3 = f3; e.rob = rob;
        q.push_back(e);
    endtask

    // One clock edge, then compare any issue against the scoreboard
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (o_issue_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_issue", {60'd0, o_issue_rob_tag}, 64'hFFFF);
            end else begin
                e = q.pop_front();
                chk("issue_cycle", 64'(cyc), 64'(e.due));
                chk("issue_op1", {32'd0, o_issue_op1}, {32'd0, e.op1});
                chk("issue_op2", {32'd0, o_issue_op2}, {32'd0, e.op2});
                chk("issue_pc", {32'd0, o_issue_pc}, {32'd0, e.pc});
                chk("issue_imm", {32'd0, o_issue_imm}, {32'd0, e.imm});
                chk("issue_funct3", {61'd0, o_issue_funct3}, {61'd0, e.f3});
                chk("issue_rob", {60'd0, o_issue_rob_tag}, {60'd0, e.rob});
            end
        end
        if (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            chk("missing_issue_rob", 64'hFFFF, {60'd0, e.rob});
        end
    endtask

    task automatic disp(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                        input logic [3:0] rob,
                        input logic s1r, input logic [5:0] s1t, input logic [31:0] s1v,
                        input logic s2r, input logic [5:0] s2t, input logic [31:0] s2v);
        i_disp_valid = 1'b1;  i_disp_pc = pc;  i_disp_imm = imm;
        i_disp_funct3 = f3;   i_disp_rob_tag = rob;
        i_disp_src1_rdy = s1r; i_disp_src1_tag = s1t; i_disp_src1_val = s1v;
        i_disp_src2_rdy = s2r; i_disp_src2_tag = s2t; i_disp_src2_val = s2v;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
        i_cdb_valid = 1'b1; i_cdb_tag = tag; i_cdb_data = data;
    endtask

    task automatic idle();
        i_disp_valid = 1'b0;
        i_cdb_valid  = 1'b0;
        i_flush      = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0; n_fail = 0; cyc = 0;
        reset = 1'b1;
        idle();
        disp(32'h0, 32'h0, 3'd0, 4'd0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        i_disp_valid = 1'b0;
        cdb(6'd0, 32'h0);
        i_cdb_valid = 1'b0;

        // Reset state
        #12;
        chk("rst_issue_valid", {63'd0, o_issue_valid}, 64'd0);
        chk("rst_count", {61'd0, o_count}, 64'd0);
        chk("rst_disp_ready", {63'd0, o_disp_ready}, 64'd1);
        chk("rst_issue_op1", {32'd0, o_issue_op1}, 64'd0);
        chk("rst_issue_pc", {32'd0, o_issue_pc}, 64'd0);
        chk("rst_issue_rob", {60'd0, o_issue_rob_tag}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Both sources ready at dispatch: issue one cycle after capture
        disp(32'h100, 32'h20, 3'b000, 4'd3, 1'b1, 6'd1, 32'd5, 1'b1, 6'd2, 32'd7);
        push(cyc + 2, 32'd5, 32'd7, 32'h100, 32'h20, 3'b000, 4'd3);
        tick(); idle();
        chk("t1_count_after_disp", {61'd0, o_count}, 64'd1);
        tick();
        chk("t1_count_after_issue", {61'd0, o_count}, 64'd0);
        tick();
        chk("t1_valid_drops", {63'd0, o_issue_valid}, 64'd0);
        chk("t1_pc_holds", {32'd0, o_issue_pc}, 64'h100);

        // src2 waits on tag 12, broadcast three cycles later
        disp(32'h200, 32'h8, 3'b001, 4'd4, 1'b1, 6'd3, 32'h11, 1'b0, 6'd12, 32'hBAD);
        tick(); idle();
        tick();
        tick();
        cdb(6'd12, 32'hDEAD);
        push(cyc + 2, 32'h11, 32'hDEAD, 32'h200, 32'h8, 3'b001, 4'd4);
        tick(); idle();
        tick();
        chk("t2_count", {61'd0, o_count}, 64'd0);

        // rob 1 waits on tag 9, rob 2 ready; wake rob 1 while rob 2 is issuing
        disp(32'h300, 32'h4, 3'b100, 4'd1, 1'b0, 6'd9, 32'h0, 1'b1, 6'd4, 32'h22);
        tick();
        disp(32'h310, 32'h8, 3'b101, 4'd2, 1'b1, 6'd5, 32'h33, 1'b1, 6'd6, 32'h44);
        push(cyc + 2, 32'h33, 32'h44, 32'h310, 32'h8, 3'b101, 4'd2);
        tick(); idle();
        tick();
        cdb(6'd9, 32'h99);
        push(cyc + 2, 32'h99, 32'h22, 32'h300, 32'h4, 3'b100, 4'd1);
        tick(); idle();
        tick();
        chk("t3_count", {61'd0, o_count}, 64'd0);

        // Fill all four entries with waiting ops (src1 tags 20..23)
        for (int k = 0; k < 4; k++) begin
            disp(32'h400 + 32'(k), 32'h10, 3'b110, 4'(8 + k), 1'b0, 6'(20 + k), 32'h0,
                 1'b1, 6'd7, 32'hA0 + 32'(k));
            tick();
        end
        idle();
        chk("t4_count_full", {61'd0, o_count}, 64'd4);
        chk("t4_ready_full", {63'd0, o_disp_ready}, 64'd0);
        disp(32'h4F0, 32'h0, 3'b000, 4'd15, 1'b1, 6'd8, 32'h1, 1'b1, 6'd8, 32'h1);
        tick(); idle();
        chk("t4_extra_ignored", {61'd0, o_count}, 64'd4);
        cdb(6'd22, 32'h222);
        push(cyc + 2, 32'h222, 32'hA2, 32'h402, 32'h10, 3'b110, 4'd10);
        tick(); idle();
        chk("t4_ready_before_issue", {63'd0, o_disp_ready}, 64'd0);
        tick();
        chk("t4_count_after_issue", {61'd0, o_count}, 64'd3);
        chk("t4_ready_after_issue", {63'd0, o_disp_ready}, 64'd1);

        // Younger rob 12 lands in lower slot 2; both wake together, rob 11 first
        disp(32'h500, 32'h18, 3'b111, 4'd12, 1'b0, 6'd23, 32'h0, 1'b1, 6'd7, 32'hC0);
        tick(); idle();
        cdb(6'd23, 32'h123);
        push(cyc + 2, 32'h123, 32'hA3, 32'h403, 32'h10, 3'b110, 4'd11);
        push(cyc + 3, 32'h123, 32'hC0, 32'h500, 32'h18, 3'b111, 4'd12);
        tick(); idle();
        tick();
        tick();
        chk("t5_count", {61'd0, o_count}, 64'd2);

        // Three valid entries; flush together with dispatch and broadcast
        disp(32'h600, 32'h0, 3'b000, 4'd13, 1'b0, 6'd25, 32'h0, 1'b1, 6'd7, 32'h1);
        tick(); idle();
        chk("t6_count_pre_flush", {61'd0, o_count}, 64'd3);
        i_flush = 1'b1;
        disp(32'h610, 32'h0, 3'b000, 4'd14, 1'b1, 6'd1, 32'h1, 1'b1, 6'd1, 32'h2);
        cdb(6'd20, 32'h20);
        tick(); idle();
        chk("t6_count_flush", {61'd0, o_count}, 64'd0);
        chk("t6_issue_valid_flush", {63'd0, o_issue_valid}, 64'd0);
        chk("t6_ready_flush", {63'd0, o_disp_ready}, 64'd1);
        cdb(6'd21, 32'h21); tick();
        cdb(6'd25, 32'h25); tick();
        cdb(6'd20, 32'h20); tick();
        idle();
        tick();
        tick();
        chk("t6_count_end", {61'd0, o_count}, 64'd0);

        // Same-cycle dispatch and broadcast of src1 tag 4
        disp(32'h700, 32'h4, 3'b101, 4'd5, 1'b0, 6'd4, 32'hBAD, 1'b1, 6'd9, 32'h66);
        cdb(6'd4, 32'h55);
`ifdef BRS_DISPATCH_BYPASS_EN
        push(cyc + 2, 32'h55, 32'h66, 32'h700, 32'h4, 3'b101, 4'd5);
`endif
        tick(); idle();
        tick();
        tick();
        tick();
`ifndef BRS_DISPATCH_BYPASS_EN
        chk("t7_still_waiting", {61'd0, o_count}, 64'd1);
        push(cyc + 2, 32'h77, 32'h66, 32'h700, 32'h4, 3'b101, 4'd5);
`endif
        cdb(6'd4, 32'h77);
        tick(); idle();
        tick();
        tick();
        chk("t7_count", {61'd0, o_count}, 64'd0);

        // Both sources woken by a single broadcast
        disp(32'h800, 32'hC, 3'b100, 4'd6, 1'b0, 6'd30, 32'h0, 1'b0, 6'd30, 32'h0);
        tick(); idle();
        tick();
        cdb(6'd30, 32'hABC);
        push(cyc + 2, 32'hABC, 32'hABC, 32'h800, 32'hC, 3'b100, 4'd6);
        tick(); idle();
        tick();
        tick();
        chk("t8_count", {61'd0, o_count}, 64'd0);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
